// File: rtl/rand_arbiter.sv
// rand_arbiter
//   One stallable xorshift32 generator (shifts 13/17/5) shared round-robin
//   between N_REQ requesters. The generator only advances when a value is
//   handed out, so every grant carries a distinct value. After reset or a
//   seed write the first WARMUP generator outputs are discarded.
//
// Ports
//   clk         clock
//   rst_n       synchronous, active-low reset (priority over seed_we)
//   req         level request per requester
//   gnt         one-hot single-cycle grant; rdata valid in the same cycle
//   rdata       value for the granted requester, holds between grants
//   seed_we     seed write strobe (any state, priority over arbitration)
//   seed_wdata  new seed; zero is replaced by DEFAULT_SEED
//   busy        high while warming up
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_WARM  | stepping generator, discarding outputs, cnt counts down
// ST_SERVE | arbitrating requests, one grant per cycle at most
module rand_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          WARMUP       = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'hCDA9D4AF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rdata,
  input  logic             seed_we,
  input  logic [31:0]      seed_wdata,
  output logic             busy
);

  localparam int          PW       = $clog2(N_REQ);
  localparam logic [7:0]  WARM_CNT = 8'(WARMUP);

  typedef enum logic {ST_WARM, ST_SERVE} state_t;

  // State entered after reset or a seed write.
  localparam state_t ST_INIT = (WARMUP > 0) ? ST_WARM : ST_SERVE;

  state_t            state, state_nxt;
  logic [31:0]       s, s_nxt, s_step;
  logic [31:0]       rdata_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [N_REQ-1:0]  elig;
  logic              found;
  logic [PW-1:0]     winner;

  function automatic logic [31:0] xs_step(input logic [31:0] v);
    logic [31:0] a, b;
    a = v ^ (v << 13);
    b = a ^ (a >> 17);
    return b ^ (b << 5);
  endfunction

  assign s_step = xs_step(s);

  // A requester whose grant is pulsing this cycle is not eligible, so a
  // held request is served at most every other cycle.
  assign elig = req & ~gnt;

  // Rotating priority scan starting at ptr.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    rdata_nxt = rdata;
    if (seed_we) begin
      s_nxt     = (seed_wdata == 32'd0) ? DEFAULT_SEED : seed_wdata;
      cnt_nxt   = WARM_CNT;
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_WARM: begin
          s_nxt   = s_step;
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = ST_SERVE;
        end
        ST_SERVE: begin
          if (found) begin
            gnt_nxt         = '0;
            gnt_nxt[winner] = 1'b1;
            rdata_nxt       = s_step;
            s_nxt           = s_step;
            ptr_nxt         = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      s     <= DEFAULT_SEED;
      cnt   <= WARM_CNT;
      ptr   <= '0;
      gnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      rdata <= rdata_nxt;
    end
  end

  assign busy = (state == ST_WARM);

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: two instances (WARMUP=0 and WARMUP=4) share the
// same stimulus; each is compared every cycle against a behavioural model,
// plus directed checks with known constants.
module tb_rand_arbiter;

  localparam logic [31:0] DEF = 32'hCDA9D4AF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        seed_we;
  logic [31:0] seed_wdata;
  logic [3:0]  gnt0, gnt4;
  logic [31:0] rdata0, rdata4;
  logic        busy0, busy4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rand_arbiter #(.N_REQ(4), .WARMUP(0), .DEFAULT_SEED(DEF)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt0), .rdata(rdata0),
    .seed_we(seed_we), .seed_wdata(seed_wdata), .busy(busy0)
  );

  rand_arbiter #(.N_REQ(4), .WARMUP(4), .DEFAULT_SEED(DEF)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt4), .rdata(rdata4),
    .seed_we(seed_we), .seed_wdata(seed_wdata), .busy(busy4)
  );

  // Reference model state, index 0 -> dut0, index 1 -> dut4.
  logic [31:0] m_s[2];
  logic [31:0] m_rdata[2];
  logic [3:0]  m_gnt[2];
  int          m_rem[2];
  int          m_ptr[2];

  function automatic int wu(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] v);
    logic [31:0] a, b;
    a = v ^ (v << 13);
    b = a ^ (a >> 17);
    return b ^ (b << 5);
  endfunction

  function automatic logic [31:0] step_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge of the spec rules to both models.
  task automatic model_edge();
    logic [3:0] elig, rot;
    logic [7:0] dbl;
    int         w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_s[i] = DEF; m_rem[i] = wu(i); m_gnt[i] = 4'b0;
        m_rdata[i] = 32'd0; m_ptr[i] = 0;
      end else if (seed_we) begin
        m_s[i]   = (seed_wdata == 32'd0) ? DEF : seed_wdata;
        m_rem[i] = wu(i);
        m_gnt[i] = 4'b0;
      end else if (m_rem[i] > 0) begin
        m_s[i] = step(m_s[i]);
        m_rem[i]--;
        m_gnt[i] = 4'b0;
      end else begin
        elig = req & ~m_gnt[i];
        dbl  = {elig, elig};
        rot  = 4'(dbl >> m_ptr[i]);
        w    = -1;
        for (int j = 3; j >= 0; j--) if (rot[j]) w = j;
        if (w >= 0) begin
          w          = (m_ptr[i] + w) % 4;
          m_s[i]     = step(m_s[i]);
          m_rdata[i] = m_s[i];
          m_gnt[i]   = 4'(1 << w);
          m_ptr[i]   = (w + 1) % 4;
        end else begin
          m_gnt[i] = 4'b0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_gnt0",   32'(gnt0),   32'(m_gnt[0]));
    chk("model_rdata0", rdata0,      m_rdata[0]);
    chk("model_busy0",  32'(busy0),  32'(m_rem[0] > 0));
    chk("model_gnt4",   32'(gnt4),   32'(m_gnt[1]));
    chk("model_rdata4", rdata4,      m_rdata[1]);
    chk("model_busy4",  32'(busy4),  32'(m_rem[1] > 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  logic [31:0] exp0, sd;
  logic [31:0] vals[$];
  int          dupes;

  initial begin
    rst_n = 1'b0; req = 4'b0; seed_we = 1'b0; seed_wdata = 32'd0;
    tick(); tick();
    chk("rst_busy4",  32'(busy4), 32'd1);
    chk("rst_busy0",  32'(busy0), 32'd0);
    chk("rst_rdata0", rdata0,     32'd0);
    chk("rst_gnt4",   32'(gnt4),  32'd0);
    rst_n = 1'b1;

    // Seed 1, single request, then re-raise two cycles later.
    seed_we = 1'b1; seed_wdata = 32'd1; tick();
    seed_we = 1'b0; req = 4'b0001; tick();
    chk("seed1_gnt",   32'(gnt0), 32'd1);
    chk("seed1_rdata", rdata0,    32'h00042021);
    req = 4'b0000; tick();
    req = 4'b0001; tick();
    chk("seed1_gnt2",   32'(gnt0), 32'd1);
    chk("seed1_rdata2", rdata0,    32'h04080601);
    req = 4'b0000; tick();

    // Zero seed falls back to the default seed.
    seed_we = 1'b1; seed_wdata = 32'd0; tick();
    seed_we = 1'b0; req = 4'b0001; tick();
    chk("seed0_rdata", rdata0, step(DEF));
    req = 4'b0000; tick();

    // Reset with all requests held: warm-up on dut4, contention on dut0.
    rst_n = 1'b0; req = 4'b1111; tick();
    chk("warm_busy_r", 32'(busy4), 32'd1);
    chk("warm_gnt_r",  32'(gnt4),  32'd0);
    rst_n = 1'b1;
    exp0 = DEF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp0 = step(exp0);
      chk("cont_gnt",   32'(gnt0), 32'(1 << ((k - 1) % 4)));
      chk("cont_rdata", rdata0,    exp0);
      vals.push_back(rdata0);
      if (k <= 3) begin
        chk("warm_busy", 32'(busy4), 32'd1);
        chk("warm_gnt",  32'(gnt4),  32'd0);
      end else if (k == 4) begin
        chk("warm_busy_end", 32'(busy4), 32'd0);
        chk("warm_gnt_end",  32'(gnt4),  32'd0);
      end else if (k == 5) begin
        chk("warm_first_gnt",   32'(gnt4), 32'd1);
        chk("warm_first_rdata", rdata4,    step_n(DEF, 5));
      end
    end
    dupes = 0;
    for (int i = 0; i < vals.size(); i++)
      for (int j = i + 1; j < vals.size(); j++)
        if (vals[i] == vals[j]) dupes++;
    chk("cont_distinct", 32'(dupes), 32'd0);

    // Held single request: grant every other cycle.
    req = 4'b0000; tick();
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("single_gnt", 32'(gnt0), (k % 2 == 0) ? 32'h4 : 32'h0);
    end

    // Seed write with a pending request: no grant on that edge.
    sd = $urandom | 32'd1;
    req = 4'b0010; seed_we = 1'b1; seed_wdata = sd; tick();
    chk("sw_gnt4",  32'(gnt4),  32'd0);
    chk("sw_gnt0",  32'(gnt0),  32'd0);
    chk("sw_busy4", 32'(busy4), 32'd1);
    seed_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) begin
        chk("sw_warm_busy", 32'(busy4), 32'd1);
        chk("sw_warm_gnt",  32'(gnt4),  32'd0);
      end else if (k == 4) begin
        chk("sw_busy_end", 32'(busy4), 32'd0);
      end else begin
        chk("sw_gnt_after",   32'(gnt4), 32'h2);
        chk("sw_rdata_after", rdata4,    step_n(sd, 5));
      end
    end

    // Random traffic with occasional reseeds and resets.
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      seed_we    = ($urandom_range(0, 31) == 0);
      seed_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      req        = 4'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1; seed_we = 1'b0; req = 4'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
